dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the processor's data-memory port. It replaces the zero-latency combinational data memory with a request/response handshake. Each accepted request completes after a fixed, parameterised latency, and writes honour per-byte enables. The block sits between a load/store unit (initiator) and on-chip word-organised RAM, and is the target the multi-cycle and pipelined cores will talk to.

## Interface
- DEPTH, 64, number of 32-bit words; word index = req_addr[31:2]
- LATENCY, 2, cycles from request acceptance to rsp_valid rising; legal range 1..15
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- req_valid  in  1  initiator presents a request
- req_ready  out  1  responder can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address; must be word aligned
- req_wdata  in  32  store data
- req_be  in  4  byte enables; be[i] gates bits [8i+7:8i]; ignored for loads
- rsp_valid  out  1  response available
- rsp_ready  in  1  initiator accepts response
- rsp_rdata  out  32  load data; 0 for stores and errors
- rsp_err  out  1  access was misaligned or out of range

## Operation
- The FSM has three states: IDLE, WAIT and RESP. Reset forces IDLE.
- **IDLE:**
  - req_ready=1.
  - On req_valid&req_ready, register we, addr, wdata and be, and load the counter with LATENCY-1.
  - Go to WAIT, or go directly to RESP when LATENCY=1.
- **WAIT:**
  - req_ready=0 and rsp_valid=0.
  - Decrement the counter each cycle.
  - On the edge where the counter is 0, perform the access and go to RESP.
- **Access at the commit edge:**
  - Error check: rsp_err = (addr[1:0]!=0) | (addr[31:2] >= DEPTH).
  - Error: no write; rsp_rdata=0.
  - Store: write only the enabled bytes; rsp_rdata=0.
  - Load: rsp_rdata = RAM[addr[31:2]], registered.
- **RESP:**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_valid&rsp_ready.
  - On that handshake edge, return to IDLE.
- Only one request is ever outstanding. Request inputs are ignored outside IDLE.
- RAM contents are not cleared by reset. Locations read before being written return X; the bench must not depend on them.

## Timing
- **Reset values:** req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. These take effect at the first clk edge with reset high.
- **Latency:** a request accepted at edge T gives rsp_valid=1 from edge T+LATENCY. The RAM write is committed at that same edge.
- **Throughput:** with rsp_ready held high, the minimum request-to-request spacing is LATENCY+1 cycles. req_ready rises the cycle after the response handshake.
- **Back-to-back:** a new request cannot be accepted in the same cycle as a response handshake (req_ready=0 in RESP).
- **Backpressure:** rsp_ready low holds RESP indefinitely with outputs unchanged.
- **Reset mid-operation:**
  - Reset in WAIT aborts the request; a store that has not reached its commit edge is not written.
  - Reset in RESP drops the response.
  - Either way, the block returns to IDLE next edge.
- **Read-after-write:** a load accepted after a store's response returns the new data.
- **Width rules:**
  - Counter width is 4 bits.
  - The address range check uses the full addr[31:2] compared against DEPTH; no wrap-around or aliasing.

## Test plan
- **Basic store/load:** store addr=0x10, wdata=0xDEADBEEF, be=4'hF, then load addr=0x10, with LATENCY=2 and rsp_ready=1.
  - rsp_valid rises 2 cycles after each acceptance.
  - Load returns 0xDEADBEEF with rsp_err=0.
  - The store's rsp_rdata is 0.
- **Byte enables:** store 0x11223344 be=F to addr 0x20, then store 0xAABBCCDD be=4'b0101 to the same address, then load.
  - Load returns 0x11BB33DD.
- **Backpressure:** issue a load of 0xDEADBEEF with rsp_ready=0 for 5 cycles after rsp_valid rises, then raise rsp_ready.
  - rsp_valid and rsp_rdata stay stable throughout; req_ready stays 0.
  - req_ready returns to 1 one cycle after the handshake.
- **Errors:**
  - Store to addr 0x22 (misaligned): rsp_err=1, and a later load of 0x20 still returns 0x11BB33DD.
  - Load from addr 0x100 with DEPTH=64: rsp_err=1, rsp_rdata=0.
- **Reset mid-WAIT:** LATENCY=4; store 0xCAFEF00D to addr 0x8 after 0x8 was previously written with 0x12345678; assert reset 2 cycles after acceptance.
  - Outputs return to reset values.
  - A subsequent load of 0x8 returns 0x12345678.
- **LATENCY=1 and throughput:** 8 back-to-back loads with rsp_ready=1.
  - Each rsp_valid rises 1 cycle after acceptance.
  - Acceptances occur exactly every 2 cycles.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//
// Memory-side responder for the data-memory port. Accepts one request at a
// time over a valid/ready handshake, completes it after a fixed latency and
// returns the result over a second valid/ready handshake. Stores honour
// per-byte enables; misaligned or out-of-range accesses are flagged and have
// no side effect.
//
// Latency convention: a request whose acceptance cycle starts at edge T has
// rsp_valid high from edge T+LATENCY, so with rsp_ready held high a new
// request can be accepted every LATENCY+1 cycles. The RAM access commits on
// the same edge that raises rsp_valid.
//
// Ports:
//   clk        in   clock, all logic on posedge
//   reset      in   synchronous active-high reset
//   req_valid  in   initiator presents a request
//   req_ready  out  responder idle and able to accept
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address (word aligned)
//   req_wdata  in   store data
//   req_be     in   byte enables for stores
//   rsp_valid  out  response available
//   rsp_ready  in   initiator accepts response
//   rsp_rdata  out  load data, 0 for stores and errors
//   rsp_err    out  access was misaligned or out of range

module dmem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;
   logic        commit;

   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  be_q;

   logic [31:0] rdata_q;
   logic        err_q;

   logic [31:0] mem [DEPTH];

   // Access operands: with LATENCY=1 the commit happens on the acceptance
   // edge itself, so the request inputs are used directly.
   logic        acc_we;
   logic [31:0] acc_addr;
   logic [31:0] acc_wdata;
   logic [3:0]  acc_be;
   logic        acc_err;
   logic [AW-1:0] acc_idx;

   always_comb begin
      if (state_q == StIdle) begin
         acc_we    = req_we;
         acc_addr  = req_addr;
         acc_wdata = req_wdata;
         acc_be    = req_be;
      end else begin
         acc_we    = we_q;
         acc_addr  = addr_q;
         acc_wdata = wdata_q;
         acc_be    = be_q;
      end
      // Full 30-bit word index is compared so high addresses never alias.
      acc_err = (acc_addr[1:0] != 2'b00) || ({2'b00, acc_addr[31:2]} >= DEPTH);
      acc_idx = acc_addr[AW+1:2];
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      commit  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               accept = 1'b1;
               cnt_d  = 4'(LATENCY - 1);
               if (LATENCY == 1) begin
                  commit  = 1'b1;
                  state_d = StResp;
               end else begin
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            // Commit on the edge where the counter runs out.
            if (cnt_q <= 4'd1) begin
               commit  = 1'b1;
               cnt_d   = 4'd0;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (commit) begin
            err_q   <= acc_err;
            rdata_q <= (!acc_err && !acc_we) ? mem[acc_idx] : 32'd0;
         end
      end
   end

   // Request capture needs no reset: it is only consumed after an accept.
   always_ff @(posedge clk) begin
      if (!reset && accept) begin
         we_q    <= req_we;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
         be_q    <= req_be;
      end
   end

   // RAM contents survive reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clk) begin
      if (!reset && commit && acc_we && !acc_err) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) begin
               mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
         end
      end
   end

   assign req_ready = (state_q == StIdle);
   assign rsp_valid = (state_q == StResp);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder. Three instances share the request inputs and
// rsp_ready: LATENCY=2 (main table), LATENCY=4 (reset mid-WAIT) and
// LATENCY=1 (throughput). Latency is counted in edges from the start of the
// acceptance cycle to the first cycle with rsp_valid high.

module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic [2:0]  valid_v;
   logic [2:0]  ready_v;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic [2:0]  rsp_valid_v;
   logic        rsp_ready;
   logic [31:0] rdata_v [3];
   logic [2:0]  err_v;

   int vec_cnt  = 0;
   int miss_cnt = 0;

   dmem_responder #(.DEPTH(64), .LATENCY(2)) u_dut_l2 (
      .clk(clk), .reset(reset), .req_valid(valid_v[0]), .req_ready(ready_v[0]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_v[0]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[0]),
      .rsp_err(err_v[0])
   );

   dmem_responder #(.DEPTH(64), .LATENCY(4)) u_dut_l4 (
      .clk(clk), .reset(reset), .req_valid(valid_v[1]), .req_ready(ready_v[1]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_v[1]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[1]),
      .rsp_err(err_v[1])
   );

   dmem_responder #(.DEPTH(64), .LATENCY(1)) u_dut_l1 (
      .clk(clk), .reset(reset), .req_valid(valid_v[2]), .req_ready(ready_v[2]),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid_v[2]), .rsp_ready(rsp_ready), .rsp_rdata(rdata_v[2]),
      .rsp_err(err_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout got running want finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      vec_cnt++;
      if (got !== want) begin
         miss_cnt++;
         $display("FAIL %s got %h want %h", name, got, want);
      end
   endtask

   // Issue one request on instance k, starting right now (just after an edge).
   task automatic run_txn(input int k, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int lat,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold, input string name);
      int cyc;
      check({name, " req_ready_idle"}, 32'(ready_v[k]), 32'd1);
      req_we    = we;
      req_addr  = addr;
      req_wdata = wdata;
      req_be    = be;
      rsp_ready = (hold == 0);
      valid_v[k] = 1'b1;
      cyc = 0;
      do begin
         @(posedge clk);
         #1;
         valid_v[k] = 1'b0;
         cyc++;
         if (!rsp_valid_v[k]) check({name, " req_ready_wait"}, 32'(ready_v[k]), 32'd0);
      end while (!rsp_valid_v[k] && cyc < 40);
      check({name, " latency"}, 32'(cyc), 32'(lat));
      check({name, " rdata"}, rdata_v[k], exp_rdata);
      check({name, " err"}, 32'(err_v[k]), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check({name, " hold_valid"}, 32'(rsp_valid_v[k]), 32'd1);
         check({name, " hold_rdata"}, rdata_v[k], exp_rdata);
         check({name, " hold_req_ready"}, 32'(ready_v[k]), 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      check({name, " post_valid"}, 32'(rsp_valid_v[k]), 32'd0);
      check({name, " post_req_ready"}, 32'(ready_v[k]), 32'd1);
   endtask

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      logic [31:0] rdata;
      logic        err;
      int          hold;
   } vec_t;

   vec_t vecs[15];
   longint t_prev, t_now;

   initial begin
      vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0, 0};
      vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 0};
      vecs[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0, 0};
      vecs[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'h5, 32'h0000_0000, 1'b0, 0};
      vecs[4]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0, 0};
      vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0, 5};
      vecs[6]  = '{1'b1, 32'h0000_0022, 32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b1, 0};
      vecs[7]  = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'h11BB_33DD, 1'b0, 0};
      vecs[8]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 0};
      vecs[9]  = '{1'b1, 32'h0000_0110, 32'h5555_5555, 4'hF, 32'h0000_0000, 1'b1, 0};
      vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF, 1'b0, 0};
      vecs[11] = '{1'b1, 32'h0000_00FC, 32'h0BAD_CAFE, 4'hF, 32'h0000_0000, 1'b0, 0};
      vecs[12] = '{1'b0, 32'h0000_00FC, 32'h0000_0000, 4'hF, 32'h0BAD_CAFE, 1'b0, 0};
      vecs[13] = '{1'b0, 32'h0000_0021, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 0};
      vecs[14] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1, 0};

      reset     = 1'b1;
      valid_v   = 3'b000;
      req_we    = 1'b0;
      req_addr  = 32'd0;
      req_wdata = 32'd0;
      req_be    = 4'h0;
      rsp_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("reset%0d req_ready", k), 32'(ready_v[k]), 32'd1);
         check($sformatf("reset%0d rsp_valid", k), 32'(rsp_valid_v[k]), 32'd0);
         check($sformatf("reset%0d rdata", k), rdata_v[k], 32'd0);
         check($sformatf("reset%0d err", k), 32'(err_v[k]), 32'd0);
      end
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Main table on the LATENCY=2 instance.
      for (int i = 0; i < 15; i++) begin
         run_txn(0, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, 2,
                 vecs[i].rdata, vecs[i].err, vecs[i].hold, $sformatf("v%0d", i));
      end

      // Reset mid-WAIT on the LATENCY=4 instance.
      run_txn(1, 1'b1, 32'h8, 32'h1234_5678, 4'hF, 4, 32'h0, 1'b0, 0, "l4_st");
      run_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 4, 32'h1234_5678, 1'b0, 0, "l4_ld");
      req_we    = 1'b1;
      req_addr  = 32'h8;
      req_wdata = 32'hCAFE_F00D;
      req_be    = 4'hF;
      valid_v[1] = 1'b1;
      @(posedge clk);
      #1;
      valid_v[1] = 1'b0;
      check("rst_wait accepted", 32'(ready_v[1]), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("rst_wait req_ready", 32'(ready_v[1]), 32'd1);
      check("rst_wait rsp_valid", 32'(rsp_valid_v[1]), 32'd0);
      check("rst_wait rdata", rdata_v[1], 32'd0);
      check("rst_wait err", 32'(err_v[1]), 32'd0);
      repeat (4) begin
         @(posedge clk);
         #1;
         check("rst_wait quiet", 32'(rsp_valid_v[1]), 32'd0);
      end
      run_txn(1, 1'b0, 32'h8, 32'h0, 4'hF, 4, 32'h1234_5678, 1'b0, 0, "l4_ld_after_rst");

      // LATENCY=1 throughput: fill 8 words, then 8 back-to-back loads.
      for (int i = 0; i < 8; i++) begin
         run_txn(2, 1'b1, 32'(i * 4), 32'h0101_0101 * 32'(i + 1), 4'hF, 1, 32'h0, 1'b0, 0,
                 $sformatf("l1_st%0d", i));
      end
      t_prev = 0;
      for (int i = 0; i < 8; i++) begin
         t_now = $time;
         if (i > 0) check($sformatf("l1_spacing%0d", i), 32'(t_now - t_prev), 32'd20);
         t_prev = t_now;
         run_txn(2, 1'b0, 32'(i * 4), 32'h0, 4'hF, 1, 32'h0101_0101 * 32'(i + 1), 1'b0, 0,
                 $sformatf("l1_ld%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
      $finish;
   end

endmodule
